// File: rtl/voice_sequencer_pkg.sv
// voice_sequencer_pkg
// Shared definitions for the voice sequencer and the note-control logic that
// feeds it: default widths, FSM state encoding and the note-update record.
// No ports (package).
package voice_sequencer_pkg;

    localparam int DEFAULT_VOICE_W = 8;
    localparam int DEFAULT_PHASE_W = 32;

    // Sweep FSM encoding, kept as plain constants for older tools downstream.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // One note-table update as produced by the MIDI note-on/off decoder.
    typedef struct packed {
        logic [DEFAULT_VOICE_W-1:0] voice;
        logic [DEFAULT_PHASE_W-1:0] delta;
        logic                       gate;
    } note_update_t;

endpackage

// File: rtl/dptrueram.sv
// dptrueram
// Codebase true dual-port RAM, read-first, one cycle read latency on both
// ports, no reset on contents.
// Ports:
//   clk                      common clock
//   we_a/addr_a/din_a/dout_a port A write enable, address, write data, read data
//   we_b/addr_b/din_b/dout_b port B write enable, address, write data, read data
module dptrueram #(
    parameter int addr_width = 8,
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  we_a,
    input  logic [addr_width-1:0] addr_a,
    input  logic [data_width-1:0] din_a,
    output logic [data_width-1:0] dout_a,
    input  logic                  we_b,
    input  logic [addr_width-1:0] addr_b,
    input  logic [data_width-1:0] din_b,
    output logic [data_width-1:0] dout_b
);

    logic [data_width-1:0] mem [2**addr_width];

    // Both ports share one process so the array has a single driver.
    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
        if (we_b) mem[addr_b] <= din_b;
        dout_a <= mem[addr_a];
        dout_b <= mem[addr_b];
    end

endmodule

// File: rtl/voice_sequencer.sv
// voice_sequencer
// Sweeps every voice once per sample tick, in consecutive index order, and
// feeds the DDS phase accumulator its voice_index / delta_phase stream. Holds
// the per-voice tuning word (RAM) and gate bit (register vector).
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   sample_tick                  one-cycle pulse at the audio sample rate
//   upd_valid/upd_ready          note-table update handshake
//   upd_voice/upd_delta/upd_gate update payload
//   voice_index/voice_valid      voice currently being read
//   delta_phase/delta_valid      tuning word for the voice one cycle earlier
//   frame_done                   pulse on the first idle cycle after a sweep
//   overrun                      sticky: a tick arrived mid-sweep
module voice_sequencer
    import voice_sequencer_pkg::*;
#(
    parameter int VOICE_W = DEFAULT_VOICE_W,
    parameter int PHASE_W = DEFAULT_PHASE_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sample_tick,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [VOICE_W-1:0] upd_voice,
    input  logic [PHASE_W-1:0] upd_delta,
    input  logic               upd_gate,
    output logic [VOICE_W-1:0] voice_index,
    output logic               voice_valid,
    output logic [PHASE_W-1:0] delta_phase,
    output logic               delta_valid,
    output logic               frame_done,
    output logic               overrun
);

    localparam int NUM_VOICES = 2**VOICE_W;

    typedef struct packed {
        logic [VOICE_W-1:0] voice;
        logic [PHASE_W-1:0] delta;
        logic               gate;
    } pending_t;

    logic [1:0]            state;
    logic [VOICE_W-1:0]    counter;
    logic [NUM_VOICES-1:0] gate_bits;
    logic                  gate_q;
    pending_t              pending;
    logic                  pending_full;

    logic                  idle_accept;
    logic                  pending_load;
    logic                  pending_commit;

    logic                  wr_en;
    logic [VOICE_W-1:0]    wr_voice;
    logic [PHASE_W-1:0]    wr_delta;
    logic                  wr_gate;

    logic [PHASE_W-1:0]    ram_rd_data;
    logic [PHASE_W-1:0]    unused_rd_b;

    // The frame_done cycle is already IDLE, but it is reserved for committing
    // the pending entry, so no new update is taken that cycle.
    assign idle_accept    = (state == ST_IDLE) && !frame_done && upd_valid;
    assign pending_load   = (state != ST_IDLE) && !pending_full && upd_valid;
    assign pending_commit = frame_done && pending_full;
    assign upd_ready      = (state == ST_IDLE) ? !frame_done : !pending_full;

    assign voice_index = counter;
    assign voice_valid = (state == ST_SWEEP);

    // RAM data arrives one cycle after the address; gate_q was captured on the
    // same edge so both refer to the same voice.
    assign delta_phase = (delta_valid && gate_q) ? ram_rd_data : {PHASE_W{1'b0}};

    // Only one write source can be active: commits happen on frame_done,
    // where direct IDLE writes are blocked.
    always_comb begin
        wr_en = idle_accept || pending_commit;
        if (pending_commit) begin
            wr_voice = pending.voice;
            wr_delta = pending.delta;
            wr_gate  = pending.gate;
        end else begin
            wr_voice = upd_voice;
            wr_delta = upd_delta;
            wr_gate  = upd_gate;
        end
    end

    dptrueram #(
        .addr_width(VOICE_W),
        .data_width(PHASE_W)
    ) u_delta_table (
        .clk    (clk),
        .we_a   (1'b0),
        .addr_a (counter),
        .din_a  ({PHASE_W{1'b0}}),
        .dout_a (ram_rd_data),
        .we_b   (wr_en),
        .addr_b (wr_voice),
        .din_b  (wr_delta),
        .dout_b (unused_rd_b)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            counter      <= '0;
            gate_bits    <= '0;
            gate_q       <= 1'b0;
            delta_valid  <= 1'b0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
            pending      <= '0;
            pending_full <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            delta_valid <= (state == ST_SWEEP);
            gate_q      <= gate_bits[counter];

            if (wr_en) gate_bits[wr_voice] <= wr_gate;

            if (pending_load) begin
                pending.voice <= upd_voice;
                pending.delta <= upd_delta;
                pending.gate  <= upd_gate;
                pending_full  <= 1'b1;
            end else if (pending_commit) begin
                pending_full  <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (sample_tick) begin
                        state   <= ST_SWEEP;
                        counter <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (sample_tick) overrun <= 1'b1;
                    // Terminal count ends the pass; the counter is parked at
                    // zero rather than wrapping into a second pass.
                    if (&counter) begin
                        state   <= ST_DRAIN;
                        counter <= '0;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (sample_tick) overrun <= 1'b1;
                    state      <= ST_IDLE;
                    frame_done <= 1'b1;
                end
                default: begin
                    state   <= ST_IDLE;
                    counter <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_sequencer.sv
// tb_voice_sequencer
// Self-checking bench for voice_sequencer with four voices. A cycle table
// drives ticks and updates and carries the expected handshake/overrun values;
// a behavioural note-table model pushes the expected per-cycle output stream
// into a scoreboard queue whenever a sweep starts. Hand-written sequences
// cover reset behaviour, including reset in the middle of a sweep.
module tb_voice_sequencer;

    localparam int VW    = 2;
    localparam int PW    = 32;
    localparam int NV    = 4;
    localparam int NROWS = 28;

    logic          clk;
    logic          reset_n;
    logic          sample_tick;
    logic          upd_valid;
    logic          upd_ready;
    logic [VW-1:0] upd_voice;
    logic [PW-1:0] upd_delta;
    logic          upd_gate;
    logic [VW-1:0] voice_index;
    logic          voice_valid;
    logic [PW-1:0] delta_phase;
    logic          delta_valid;
    logic          frame_done;
    logic          overrun;

    voice_sequencer #(
        .VOICE_W(VW),
        .PHASE_W(PW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_voice   (upd_voice),
        .upd_delta   (upd_delta),
        .upd_gate    (upd_gate),
        .voice_index (voice_index),
        .voice_valid (voice_valid),
        .delta_phase (delta_phase),
        .delta_valid (delta_valid),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic          vv;
        logic [VW-1:0] vi;
        logic          dv;
        logic [PW-1:0] dp;
        logic          fd;
    } exp_t;

    typedef struct {
        bit            tick;
        bit            uv;
        logic [VW-1:0] voice;
        logic [PW-1:0] delta;
        bit            gate;
        bit            exp_ready;
        bit            exp_overrun;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[NROWS];

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    logic [PW-1:0] m_delta [NV];
    bit            m_gate  [NV];
    bit            m_pv;
    logic [VW-1:0] m_pvoice;
    logic [PW-1:0] m_pdelta;
    bit            m_pgate;
    int            m_fd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_voice_valid"}, 64'(voice_valid), 64'd0);
        check({tag, "_voice_index"}, 64'(voice_index), 64'd0);
        check({tag, "_delta_valid"}, 64'(delta_valid), 64'd0);
        check({tag, "_delta_phase"}, 64'(delta_phase), 64'd0);
        check({tag, "_frame_done"},  64'(frame_done),  64'd0);
        check({tag, "_overrun"},     64'(overrun),     64'd0);
        check({tag, "_upd_ready"},   64'(upd_ready),   64'd1);
    endtask

    task automatic modelReset();
        for (int i = 0; i < NV; i++) m_gate[i] = 1'b0;
        m_pv = 1'b0;
        m_fd = -100;
    endtask

    // Compare the whole output stream for the current cycle against the
    // scoreboard; cycles with no queued entry must be idle.
    task automatic checkOutput();
        exp_t e;
        e.cyc = cyc; e.vv = 1'b0; e.vi = '0; e.dv = 1'b0; e.dp = '0; e.fd = 1'b0;
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) e = sb_q.pop_front();
        check("stream{vv,vi,dv,dp,fd}",
              {27'd0, voice_valid, voice_index, delta_valid, delta_phase, frame_done},
              {27'd0, e.vv, e.vi, e.dv, e.dp, e.fd});
    endtask

    // Drive this cycle's inputs and advance the note-table model.
    task automatic applyStimulus(input bit tick, input bit uv, input logic [VW-1:0] voice,
                                 input logic [PW-1:0] delta, input bit gate);
        bit idle;
        bit fd_cycle;
        sample_tick = tick;
        upd_valid   = uv;
        upd_voice   = voice;
        upd_delta   = delta;
        upd_gate    = gate;

        idle     = (cyc >= m_fd);
        fd_cycle = (cyc == m_fd);
        if (fd_cycle && m_pv) begin
            m_delta[m_pvoice] = m_pdelta;
            m_gate[m_pvoice]  = m_pgate;
            m_pv = 1'b0;
        end
        if (uv) begin
            if (idle && !fd_cycle) begin
                m_delta[voice] = delta;
                m_gate[voice]  = gate;
            end else if (!idle && !m_pv) begin
                m_pv = 1'b1; m_pvoice = voice; m_pdelta = delta; m_pgate = gate;
            end
        end
        if (tick && idle) begin
            for (int j = 1; j <= NV + 2; j++) begin
                exp_t e;
                e.cyc = cyc + j;
                e.vv  = (j <= NV);
                e.vi  = (j <= NV) ? VW'(j - 1) : '0;
                e.dv  = (j >= 2) && (j <= NV + 1);
                e.dp  = '0;
                if (e.dv && m_gate[j - 2]) e.dp = m_delta[j - 2];
                e.fd  = (j == NV + 2);
                sb_q.push_back(e);
            end
            m_fd = cyc + NV + 2;
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        sample_tick = 1'b0;
        upd_valid   = 1'b0;
        upd_voice   = '0;
        upd_delta   = '0;
        upd_gate    = 1'b0;
        for (int i = 0; i < NV; i++) m_delta[i] = '0;
        m_pvoice = '0; m_pdelta = '0; m_pgate = 1'b0;
        modelReset();

        #3;
        checkResetOutputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int r = 0; r < NROWS; r++)
            vecs[r] = '{tick:1'b0, uv:1'b0, voice:'0, delta:'0, gate:1'b0,
                        exp_ready:1'b1, exp_overrun:(r >= 19)};
        vecs[0].tick = 1'b1;
        vecs[6].exp_ready = 1'b0;
        vecs[7].uv = 1'b1;  vecs[7].voice = 2'd2;  vecs[7].delta = 32'h0010_0000;  vecs[7].gate = 1'b1;
        vecs[8].tick = 1'b1;
        vecs[14].exp_ready = 1'b0;
        vecs[15].tick = 1'b1;
        vecs[15].uv = 1'b1; vecs[15].voice = 2'd0; vecs[15].delta = 32'h0000_0AAA; vecs[15].gate = 1'b1;
        vecs[17].uv = 1'b1; vecs[17].voice = 2'd1; vecs[17].delta = 32'h0000_1234; vecs[17].gate = 1'b1;
        vecs[18].tick = 1'b1; vecs[18].exp_ready = 1'b0;
        vecs[19].uv = 1'b1; vecs[19].voice = 2'd3; vecs[19].delta = 32'h0000_0077; vecs[19].gate = 1'b1;
        vecs[19].exp_ready = 1'b0;
        vecs[20].exp_ready = 1'b0;
        vecs[21].tick = 1'b1; vecs[21].exp_ready = 1'b0;
        vecs[21].uv = 1'b1; vecs[21].voice = 2'd3; vecs[21].delta = 32'h0000_0055; vecs[21].gate = 1'b1;
        vecs[27].exp_ready = 1'b0;

        for (int r = 0; r < NROWS; r++) begin
            checkOutput();
            check("upd_ready", 64'(upd_ready), 64'(vecs[r].exp_ready));
            check("overrun",   64'(overrun),   64'(vecs[r].exp_overrun));
            applyStimulus(vecs[r].tick, vecs[r].uv, vecs[r].voice, vecs[r].delta, vecs[r].gate);
            stepClock();
        end

        // Reset asserted in the middle of a sweep, away from the clock edge.
        $display("[TB] reset in mid-sweep");
        checkOutput();
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
        stepClock();
        for (int i = 0; i < 2; i++) begin
            checkOutput();
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
            stepClock();
        end
        checkOutput();
        #1 reset_n = 1'b0;
        #1;
        checkResetOutputs("mid_reset");
        sb_q.delete();
        modelReset();
        for (int i = 0; i < 3; i++) begin
            stepClock();
            checkOutput();
        end
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            stepClock();
            checkOutput();
        end
        check("overrun_after_reset",   64'(overrun),   64'd0);
        check("upd_ready_after_reset", 64'(upd_ready), 64'd1);

        // Gates were cleared by reset, so every voice must come out silent.
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < NV + 3; i++) begin
            checkOutput();
            stepClock();
        end
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
